// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: opcode/funct encodings, ALU codes and datapath defaults shared by
// the ID/EX stage, the ALU and the control unit.
package mips_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_XOR   = 6'h26;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_NONE = 3'b111;

   typedef enum logic [1:0] {
      BSEL_RT   = 2'd0,
      BSEL_SEXT = 2'd1,
      BSEL_ZEXT = 2'd2
   } bsel_e;

   typedef enum logic [1:0] {
      DEST_NONE = 2'd0,
      DEST_RD   = 2'd1,
      DEST_RT   = 2'd2
   } dsel_e;

   typedef struct packed {
      logic [2:0] alu_ctrl;
      bsel_e      bsel;
      dsel_e      dsel;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       illegal;
   } dec_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// id_ex_stage_if: ID-side inputs, bypass sources and registered EX-side
// outputs of the ID/EX pipeline register.
interface id_ex_stage_if
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
);
   logic              stall;
   logic              flush;
   logic              in_valid;
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [REG_AW-1:0] rd;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [15:0]       imm16;
   logic              fwd_ex_wr;
   logic [REG_AW-1:0] fwd_ex_rd;
   logic [DATA_W-1:0] fwd_ex_data;
   logic              fwd_wb_wr;
   logic [REG_AW-1:0] fwd_wb_rd;
   logic [DATA_W-1:0] fwd_wb_data;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [2:0]        alu_ctrl;
   logic [DATA_W-1:0] ex_store_data;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_branch;
   logic              ex_valid;
   logic              ex_illegal;

   modport master (
      output stall, flush, in_valid, opcode, funct, rs, rt, rd,
             rs_data, rt_data, imm16,
             fwd_ex_wr, fwd_ex_rd, fwd_ex_data,
             fwd_wb_wr, fwd_wb_rd, fwd_wb_data,
      input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
             ex_valid, ex_illegal
   );

   modport slave (
      input  stall, flush, in_valid, opcode, funct, rs, rt, rd,
             rs_data, rt_data, imm16,
             fwd_ex_wr, fwd_ex_rd, fwd_ex_data,
             fwd_wb_wr, fwd_wb_rd, fwd_wb_data,
      output alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
             ex_valid, ex_illegal
   );

endinterface
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// alu_decode: combinational opcode/funct decode into ALU code, B-operand
// source, destination select, control bits and an illegal flag.
module alu_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output dec_t       dec_o
);

   always_comb begin
      // Anything not matched below stays an illegal, side-effect-free op.
      dec_o.alu_ctrl  = ALU_NONE;
      dec_o.bsel      = BSEL_RT;
      dec_o.dsel      = DEST_NONE;
      dec_o.reg_write = 1'b0;
      dec_o.mem_read  = 1'b0;
      dec_o.mem_write = 1'b0;
      dec_o.branch    = 1'b0;
      dec_o.illegal   = 1'b1;

      case (opcode_i)
         OP_RTYPE: begin
            if (funct_i == FN_ADD || funct_i == FN_SUB || funct_i == FN_XOR) begin
               dec_o.dsel      = DEST_RD;
               dec_o.reg_write = 1'b1;
               dec_o.illegal   = 1'b0;
               case (funct_i)
                  FN_SUB:  dec_o.alu_ctrl = ALU_SUB;
                  FN_XOR:  dec_o.alu_ctrl = ALU_XOR;
                  default: dec_o.alu_ctrl = ALU_ADD;
               endcase
            end
         end
         OP_ADDI: begin
            dec_o.alu_ctrl  = ALU_ADD;
            dec_o.bsel      = BSEL_SEXT;
            dec_o.dsel      = DEST_RT;
            dec_o.reg_write = 1'b1;
            dec_o.illegal   = 1'b0;
         end
         OP_XORI: begin
            dec_o.alu_ctrl  = ALU_XOR;
            dec_o.bsel      = BSEL_ZEXT;
            dec_o.dsel      = DEST_RT;
            dec_o.reg_write = 1'b1;
            dec_o.illegal   = 1'b0;
         end
         OP_LW: begin
            dec_o.alu_ctrl  = ALU_ADD;
            dec_o.bsel      = BSEL_SEXT;
            dec_o.dsel      = DEST_RT;
            dec_o.reg_write = 1'b1;
            dec_o.mem_read  = 1'b1;
            dec_o.illegal   = 1'b0;
         end
         OP_SW: begin
            dec_o.alu_ctrl  = ALU_ADD;
            dec_o.bsel      = BSEL_SEXT;
            dec_o.mem_write = 1'b1;
            dec_o.illegal   = 1'b0;
         end
         OP_BEQ: begin
            dec_o.alu_ctrl  = ALU_SUB;
            dec_o.branch    = 1'b1;
            dec_o.illegal   = 1'b0;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// id_ex_stage: ID/EX pipeline register with decode, immediate select and
// EX/WB operand bypass resolved at capture; supports stall and flush.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
)(
   input  logic         clk,
   input  logic         reset,
   id_ex_stage_if.slave bus
);

   dec_t              dec;
   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_zext;

   logic [DATA_W-1:0] alu_a_d,      alu_a_q;
   logic [DATA_W-1:0] alu_b_d,      alu_b_q;
   logic [2:0]        alu_ctrl_d,   alu_ctrl_q;
   logic [DATA_W-1:0] store_data_d, store_data_q;
   logic [REG_AW-1:0] ex_rd_d,      ex_rd_q;
   logic              reg_write_d,  reg_write_q;
   logic              mem_read_d,   mem_read_q;
   logic              mem_write_d,  mem_write_q;
   logic              branch_d,     branch_q;
   logic              valid_d,      valid_q;
   logic              illegal_d,    illegal_q;

   alu_decode u_alu_decode (
      .opcode_i (bus.opcode),
      .funct_i  (bus.funct),
      .dec_o    (dec)
   );

   // $0 is hardwired, so a producer "writing" it must never be bypassed.
   always_comb begin
      rs_fwd = bus.rs_data;
      if (bus.rs != '0) begin
         if (bus.fwd_ex_wr && bus.fwd_ex_rd == bus.rs)
            rs_fwd = bus.fwd_ex_data;
         else if (bus.fwd_wb_wr && bus.fwd_wb_rd == bus.rs)
            rs_fwd = bus.fwd_wb_data;
      end
   end

   always_comb begin
      rt_fwd = bus.rt_data;
      if (bus.rt != '0) begin
         if (bus.fwd_ex_wr && bus.fwd_ex_rd == bus.rt)
            rt_fwd = bus.fwd_ex_data;
         else if (bus.fwd_wb_wr && bus.fwd_wb_rd == bus.rt)
            rt_fwd = bus.fwd_wb_data;
      end
   end

   assign imm_sext = {{(DATA_W-16){bus.imm16[15]}}, bus.imm16};
   assign imm_zext = {{(DATA_W-16){1'b0}}, bus.imm16};

   always_comb begin
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_ctrl_d   = ALU_NONE;
      store_data_d = '0;
      ex_rd_d      = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      branch_d     = 1'b0;
      valid_d      = 1'b0;
      illegal_d    = 1'b0;

      if (bus.in_valid) begin
         valid_d      = 1'b1;
         illegal_d    = dec.illegal;
         alu_ctrl_d   = dec.alu_ctrl;
         reg_write_d  = dec.reg_write;
         mem_read_d   = dec.mem_read;
         mem_write_d  = dec.mem_write;
         branch_d     = dec.branch;
         alu_a_d      = rs_fwd;
         store_data_d = rt_fwd;

         case (dec.bsel)
            BSEL_SEXT: alu_b_d = imm_sext;
            BSEL_ZEXT: alu_b_d = imm_zext;
            default:   alu_b_d = rt_fwd;
         endcase

         case (dec.dsel)
            DEST_RD: ex_rd_d = bus.rd;
            DEST_RT: ex_rd_d = bus.rt;
            default: ex_rd_d = '0;
         endcase
      end
   end

   // Flush wins over stall so a squashed instruction cannot be held in EX.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= ALU_NONE;
         store_data_q <= '0;
         ex_rd_q      <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         branch_q     <= 1'b0;
         valid_q      <= 1'b0;
         illegal_q    <= 1'b0;
      end else if (bus.flush) begin
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= ALU_NONE;
         store_data_q <= '0;
         ex_rd_q      <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         branch_q     <= 1'b0;
         valid_q      <= 1'b0;
         illegal_q    <= 1'b0;
      end else if (!bus.stall) begin
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         store_data_q <= store_data_d;
         ex_rd_q      <= ex_rd_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         branch_q     <= branch_d;
         valid_q      <= valid_d;
         illegal_q    <= illegal_d;
      end
   end

   assign bus.alu_a         = alu_a_q;
   assign bus.alu_b         = alu_b_q;
   assign bus.alu_ctrl      = alu_ctrl_q;
   assign bus.ex_store_data = store_data_q;
   assign bus.ex_rd         = ex_rd_q;
   assign bus.ex_reg_write  = reg_write_q;
   assign bus.ex_mem_read   = mem_read_q;
   assign bus.ex_mem_write  = mem_write_q;
   assign bus.ex_branch     = branch_q;
   assign bus.ex_valid      = valid_q;
   assign bus.ex_illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// tb_id_ex_stage: scoreboard bench; a driver pushes the expected EX-stage state
// for each edge, a monitor pops and compares it after the edge.
`timescale 1ns/1ps
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

   id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [2:0]  ctrl;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        v;
      logic        ill;
      bit          dmask;   // data fields not defined for illegal ops
   } exp_t;

   exp_t q[$];
   exp_t state;
   int   checks = 0;
   int   errors = 0;
   logic [5:0] ops [8] = '{6'h00, 6'h00, 6'h08, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h3F};
   logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h26, 6'h21};

   function automatic exp_t bubble();
      exp_t e;
      e.a = 0; e.b = 0; e.sd = 0; e.ctrl = 3'b111; e.rd = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.v = 0; e.ill = 0; e.dmask = 0;
      return e;
   endfunction

   function automatic logic [31:0] byp(logic [4:0] r, logic [31:0] rf);
      if (r == 0) return rf;
      if (bus.fwd_ex_wr && bus.fwd_ex_rd == r) return bus.fwd_ex_data;
      if (bus.fwd_wb_wr && bus.fwd_wb_rd == r) return bus.fwd_wb_data;
      return rf;
   endfunction

   function automatic exp_t model_load();
      exp_t e;
      logic [31:0] va, vt, se, ze;
      e  = bubble();
      if (!bus.in_valid) return e;
      va = byp(bus.rs, bus.rs_data);
      vt = byp(bus.rt, bus.rt_data);
      se = 32'(signed'(bus.imm16));
      ze = 32'(bus.imm16);
      e.v = 1; e.a = va; e.sd = vt;
      if (bus.opcode == 6'h00 && bus.funct == 6'h20) begin e.ctrl = 3'b000; e.b = vt; e.rd = bus.rd; e.rw = 1; end
      else if (bus.opcode == 6'h00 && bus.funct == 6'h22) begin e.ctrl = 3'b001; e.b = vt; e.rd = bus.rd; e.rw = 1; end
      else if (bus.opcode == 6'h00 && bus.funct == 6'h26) begin e.ctrl = 3'b010; e.b = vt; e.rd = bus.rd; e.rw = 1; end
      else if (bus.opcode == 6'h08) begin e.ctrl = 3'b000; e.b = se; e.rd = bus.rt; e.rw = 1; end
      else if (bus.opcode == 6'h0E) begin e.ctrl = 3'b010; e.b = ze; e.rd = bus.rt; e.rw = 1; end
      else if (bus.opcode == 6'h23) begin e.ctrl = 3'b000; e.b = se; e.rd = bus.rt; e.rw = 1; e.mr = 1; end
      else if (bus.opcode == 6'h2B) begin e.ctrl = 3'b000; e.b = se; e.rd = 0; e.mw = 1; end
      else if (bus.opcode == 6'h04) begin e.ctrl = 3'b001; e.b = vt; e.rd = 0; e.br = 1; end
      else begin e.ctrl = 3'b111; e.ill = 1; e.dmask = 1; end
      return e;
   endfunction

   task automatic compare(input exp_t e, input string nm);
      bit ok;
      checks++;
      ok = (bus.alu_ctrl === e.ctrl) && (bus.ex_valid === e.v) && (bus.ex_illegal === e.ill) &&
           (bus.ex_reg_write === e.rw) && (bus.ex_mem_read === e.mr) &&
           (bus.ex_mem_write === e.mw) && (bus.ex_branch === e.br);
      if (!e.dmask)
         ok = ok && (bus.alu_a === e.a) && (bus.alu_b === e.b) &&
              (bus.ex_store_data === e.sd) && (bus.ex_rd === e.rd);
      if (!ok) begin
         errors++;
         $display("FAIL %s @%0t: got a=%h b=%h sd=%h ctrl=%b rd=%0d rw=%b mr=%b mw=%b br=%b v=%b ill=%b | exp a=%h b=%h sd=%h ctrl=%b rd=%0d rw=%b mr=%b mw=%b br=%b v=%b ill=%b",
                  nm, $time, bus.alu_a, bus.alu_b, bus.ex_store_data, bus.alu_ctrl, bus.ex_rd,
                  bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch,
                  bus.ex_valid, bus.ex_illegal,
                  e.a, e.b, e.sd, e.ctrl, e.rd, e.rw, e.mr, e.mw, e.br, e.v, e.ill);
      end
   endtask

   // Monitor: outputs settle on the rising edge; compare 1 ns later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            compare(e, "scoreboard");
         end
      end
   end

   task automatic clear_inputs();
      bus.stall = 0; bus.flush = 0; bus.in_valid = 0;
      bus.opcode = 0; bus.funct = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
      bus.rs_data = 0; bus.rt_data = 0; bus.imm16 = 0;
      bus.fwd_ex_wr = 0; bus.fwd_ex_rd = 0; bus.fwd_ex_data = 0;
      bus.fwd_wb_wr = 0; bus.fwd_wb_rd = 0; bus.fwd_wb_data = 0;
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
      bus.in_valid = 1; bus.opcode = op; bus.funct = fn;
      bus.rs = rs; bus.rt = rt; bus.rd = rd;
      bus.rs_data = rsd; bus.rt_data = rtd; bus.imm16 = imm;
   endtask

   // Called at the negedge once inputs are set: predicts the next edge.
   task automatic issue();
      if (bus.flush)       state = bubble();
      else if (!bus.stall) state = model_load();
      q.push_back(state);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      logic [15:0] imm;
      bus.stall    = ($urandom_range(0, 9) < 2);
      bus.flush    = ($urandom_range(0, 9) < 1);
      imm          = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      set_instr(($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 7)],
                fns[$urandom_range(0, 3)],
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                $urandom, $urandom, imm);
      bus.in_valid    = ($urandom_range(0, 7) != 0);
      bus.fwd_ex_wr   = 1'($urandom);
      bus.fwd_ex_rd   = 5'($urandom_range(0, 7));
      bus.fwd_ex_data = $urandom;
      bus.fwd_wb_wr   = 1'($urandom);
      bus.fwd_wb_rd   = 5'($urandom_range(0, 7));
      bus.fwd_wb_data = $urandom;
   endtask

   initial begin
      clear_inputs();
      state = bubble();
      repeat (2) @(posedge clk);
      #1 compare(bubble(), "reset_state");
      @(negedge clk);
      reset = 1;

      // add $3,$1,$2
      set_instr(6'h00, 6'h20, 1, 2, 3, 32'd5, 32'd7, 16'h0);
      issue();
      // addi / xori with all-ones immediate
      set_instr(6'h08, 6'h00, 1, 2, 3, 32'd5, 32'd7, 16'hFFFF);
      issue();
      set_instr(6'h0E, 6'h00, 1, 2, 3, 32'd5, 32'd7, 16'hFFFF);
      issue();
      // EX beats WB on the same register
      set_instr(6'h00, 6'h22, 4, 5, 6, 32'h11, 32'h22, 16'h0);
      bus.fwd_ex_wr = 1; bus.fwd_ex_rd = 4; bus.fwd_ex_data = 32'hAA;
      bus.fwd_wb_wr = 1; bus.fwd_wb_rd = 4; bus.fwd_wb_data = 32'hBB;
      issue();
      // WB-only bypass into rt for a store
      set_instr(6'h2B, 6'h00, 1, 4, 0, 32'h100, 32'h22, 16'h0010);
      bus.fwd_ex_rd = 9;
      issue();
      // $0 is never forwarded
      set_instr(6'h00, 6'h26, 0, 0, 7, 32'h1234, 32'h5678, 16'h0);
      bus.fwd_ex_wr = 1; bus.fwd_ex_rd = 0; bus.fwd_ex_data = 32'hDEAD;
      bus.fwd_wb_wr = 1; bus.fwd_wb_rd = 0; bus.fwd_wb_data = 32'hBEEF;
      issue();
      bus.fwd_ex_wr = 0; bus.fwd_wb_wr = 0;
      // stall two cycles with new inputs, then stall+flush
      bus.stall = 1;
      set_instr(6'h23, 6'h00, 2, 3, 4, 32'h9, 32'h8, 16'h7FFF);
      issue();
      set_instr(6'h04, 6'h00, 2, 3, 4, 32'h9, 32'h8, 16'h7FFF);
      issue();
      bus.flush = 1;
      issue();
      bus.stall = 0; bus.flush = 0;
      // beq, lw, illegal opcode, in_valid=0
      set_instr(6'h04, 6'h00, 2, 3, 4, 32'h9, 32'h8, 16'h0004);
      issue();
      set_instr(6'h23, 6'h00, 2, 3, 4, 32'h9, 32'h8, 16'h8000);
      issue();
      set_instr(6'h3F, 6'h20, 2, 3, 4, 32'h9, 32'h8, 16'h0);
      issue();
      set_instr(6'h00, 6'h20, 2, 3, 4, 32'h9, 32'h8, 16'h0);
      bus.in_valid = 0;
      issue();

      for (int i = 0; i < 200; i++) begin
         rand_inputs();
         issue();
      end

      // asynchronous reset while stalled, between clock edges
      set_instr(6'h00, 6'h20, 1, 2, 3, 32'd5, 32'd7, 16'h0);
      issue();
      bus.stall = 1;
      #3 reset = 0;
      #1 compare(bubble(), "async_reset");
      state = bubble();
      @(negedge clk);
      bus.stall = 0;
      reset = 1;

      for (int i = 0; i < 200; i++) begin
         rand_inputs();
         issue();
      end

      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
